// File: rtl/acc_bank_alu_pkg.sv
// Shared types for the accumulator-bank datapath: operand source select,
// ALU opcode map and multiply/divide sequencer states.
// Pure declarations; no timing or flow-control behaviour of its own.
package acc_bank_alu_pkg;

  // Operand B source. Bit 0 low always selects memory, so 2'b10 aliases memory.
  typedef enum logic [1:0] {
    SRC_MEM     = 2'b00,
    SRC_IMM     = 2'b01,
    SRC_MEM_ALT = 2'b10,
    SRC_REG     = 2'b11
  } data_src_t;

  // Reserved codes are named so every 4-bit value is a legal enum member.
  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_ADC   = 4'd1,
    OP_SUB   = 4'd2,
    OP_SBB   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_XOR   = 4'd6,
    OP_LD    = 4'd7,
    OP_MULU  = 4'd8,
    OP_DIVU  = 4'd9,
    OP_RSV10 = 4'd10,
    OP_RSV11 = 4'd11,
    OP_RSV12 = 4'd12,
    OP_RSV13 = 4'd13,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  function automatic logic is_mdu_op(input alu_op_t o);
    return (o == OP_MULU) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/acc_bank_alu_seq_mdu.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per clock.
// Latency: WIDTH clocks after start; last_iter flags the clock whose edge finishes.
// Backpressure: none; caller must only pulse start while the engine is idle.
// Ports: clk/rst, start+is_div+a+b (load), lo/hi (result after the step taken at
//        the next edge), div0 (divisor was zero), last_iter (next edge is final step).
module seq_mdu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             div0,
  output logic             last_iter
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] lo_q, hi_q, b_q;
  logic             div_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_geq;
  logic [WIDTH-1:0] step_lo, step_hi;

  // Multiply: {hi,lo} starts as {0,a}; each step conditionally adds b into hi
  // and shifts the whole pair right, pulling the add carry into hi's MSB.
  // Divide: {hi,lo} starts as {0,a}; each step shifts the next dividend bit into
  // the partial remainder and records a quotient bit in lo's LSB. With b == 0
  // every trial subtract succeeds, giving an all-ones quotient and remainder a.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_geq   = (div_shift >= {1'b0, b_q});
    div_diff  = div_shift - {1'b0, b_q};
    if (div_q) begin
      step_hi = div_geq ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_geq};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_q  <= '0;
      hi_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      lo_q  <= a;
      hi_q  <= '0;
      b_q   <= b;
      div_q <= is_div;
      cnt_q <= CW'(WIDTH);
    end else if (cnt_q != '0) begin
      lo_q  <= step_lo;
      hi_q  <= step_hi;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign lo        = step_lo;
  assign hi        = step_hi;
  assign div0      = div_q && (b_q == '0);
  assign last_iter = (cnt_q == CW'(1));

endmodule

// File: rtl/alu_in_mux.sv
// ALU operand-B select between memory, immediate and register-file operands.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
// Ports: data_src (select), immediate/reg_out/mem_out (candidates), alu_in (selected operand).
module alu_in_mux
  import acc_bank_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  data_src_t        data_src,
  input  logic [WIDTH-1:0] immediate,
  input  logic [WIDTH-1:0] reg_out,
  input  logic [WIDTH-1:0] mem_out,
  output logic [WIDTH-1:0] alu_in
);

  always_comb begin
    alu_in = mem_out;
    if (data_src[0]) begin
      alu_in = data_src[1] ? reg_out : immediate;
    end
  end

endmodule

// File: rtl/acc_bank_alu.sv
// Bank of NUM_ACC accumulators with per-accumulator carry/overflow, single-cycle
// ALU ops and optional multi-cycle MULU/DIVU writing a shared hi register.
// Latency: ops 0-7 and reserved -> done next cycle; MULU/DIVU -> done WIDTH cycles
// after the accepting edge. Backpressure: start ignored while busy.
// Ports: clk/rst, operand mux inputs, acc_sel/op/start/ce_cy (issue), alu_in,
//        acc_v/acc_hi/flag_* (views of selected state), busy/done (handshake).
module acc_bank_alu
  import acc_bank_alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_ACC = 4,
  parameter int MDU_EN  = 1,
  localparam int AW     = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  data_src_t        data_src,
  input  logic [WIDTH-1:0] immediate,
  input  logic [WIDTH-1:0] reg_out,
  input  logic [WIDTH-1:0] mem_out,
  input  logic [AW-1:0]    acc_sel,
  input  alu_op_t          op,
  input  logic             start,
  input  logic             ce_cy,
  output logic [WIDTH-1:0] alu_in,
  output logic [WIDTH-1:0] acc_v,
  output logic [WIDTH-1:0] acc_hi,
  output logic             flag_cy,
  output logic             flag_o,
  output logic             flag_z,
  output logic             flag_s,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] acc_q [NUM_ACC];
  logic [NUM_ACC-1:0] cy_q, ov_q;
  logic [WIDTH-1:0] hi_q;
  logic [AW-1:0]    dst_q;
  logic             div_q;
  logic             done_sc_q;
  mdu_state_t       state_q, state_d;

  logic             sel_ok, dst_ok;
  logic [WIDTH-1:0] a_op, b_op;
  logic             accept, issue_mdu, issue_alu;
  logic             mdu_start;

  logic [WIDTH:0]   sum_w, dif_w;
  logic [WIDTH-1:0] res;
  logic             res_cy, res_ov;

  logic [WIDTH-1:0] mdu_lo, mdu_hi;
  logic             mdu_div0, mdu_last;

  alu_in_mux #(.WIDTH(WIDTH)) u_mux (
    .data_src  (data_src),
    .immediate (immediate),
    .reg_out   (reg_out),
    .mem_out   (mem_out),
    .alu_in    (b_op)
  );

  // Select values beyond NUM_ACC (non power-of-two banks) read as zero and never write.
  assign sel_ok = (32'(acc_sel) < NUM_ACC);
  assign dst_ok = (32'(dst_q) < NUM_ACC);

  assign a_op    = sel_ok ? acc_q[acc_sel] : '0;
  assign alu_in  = b_op;
  assign acc_v   = a_op;
  assign acc_hi  = hi_q;
  assign flag_cy = sel_ok ? cy_q[acc_sel] : 1'b0;
  assign flag_o  = sel_ok ? ov_q[acc_sel] : 1'b0;
  assign flag_z  = (acc_v == '0);
  assign flag_s  = acc_v[WIDTH-1];

  assign accept    = start && (state_q == IDLE);
  assign issue_mdu = accept && (MDU_EN != 0) && is_mdu_op(op);
  assign issue_alu = accept && !op[3];

  // Single-cycle datapath; carry-in comes from the selected accumulator's own flag.
  always_comb begin
    res    = '0;
    res_cy = 1'b0;
    res_ov = 1'b0;
    sum_w  = {1'b0, a_op} + {1'b0, b_op} + {{WIDTH{1'b0}}, (op == OP_ADC) & flag_cy};
    dif_w  = {1'b0, a_op} - {1'b0, b_op} - {{WIDTH{1'b0}}, (op == OP_SBB) & flag_cy};
    case (op)
      OP_ADD, OP_ADC: begin
        res    = sum_w[WIDTH-1:0];
        res_cy = sum_w[WIDTH];
        res_ov = (a_op[WIDTH-1] == b_op[WIDTH-1]) && (res[WIDTH-1] != a_op[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        res    = dif_w[WIDTH-1:0];
        res_cy = dif_w[WIDTH];  // borrow out of the MSB
        res_ov = (a_op[WIDTH-1] != b_op[WIDTH-1]) && (res[WIDTH-1] != a_op[WIDTH-1]);
      end
      OP_AND:  res = a_op & b_op;
      OP_OR:   res = a_op | b_op;
      OP_XOR:  res = a_op ^ b_op;
      OP_LD:   res = b_op;
      default: res = '0;
    endcase
  end

  // Handshake FSM
  always_comb begin
    state_d   = state_q;
    mdu_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue_mdu) begin
          state_d   = RUN;
          mdu_start = 1'b1;
        end
      end
      RUN:     if (mdu_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE) || done_sc_q;

  generate
    if (MDU_EN != 0) begin : g_mdu
      seq_mdu #(.WIDTH(WIDTH)) u_mdu (
        .clk       (clk),
        .rst       (rst),
        .start     (mdu_start),
        .is_div    (op == OP_DIVU),
        .a         (a_op),
        .b         (b_op),
        .lo        (mdu_lo),
        .hi        (mdu_hi),
        .div0      (mdu_div0),
        .last_iter (mdu_last)
      );
    end else begin : g_no_mdu
      assign mdu_lo   = '0;
      assign mdu_hi   = '0;
      assign mdu_div0 = 1'b0;
      assign mdu_last = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
      cy_q      <= '0;
      ov_q      <= '0;
      hi_q      <= '0;
      dst_q     <= '0;
      div_q     <= 1'b0;
      done_sc_q <= 1'b0;
    end else begin
      // Everything accepted that is not a multi-cycle op reports done next cycle.
      done_sc_q <= accept && !issue_mdu;

      if (issue_mdu) begin
        dst_q <= acc_sel;
        div_q <= (op == OP_DIVU);
      end

      if (issue_alu && sel_ok) begin
        acc_q[acc_sel] <= res;
        ov_q[acc_sel]  <= res_ov;
        if (ce_cy) cy_q[acc_sel] <= res_cy;
      end

      // The edge that performs the final iteration also commits the result.
      if ((state_q == RUN) && mdu_last) begin
        hi_q <= mdu_hi;
        if (dst_ok) begin
          acc_q[dst_q] <= mdu_lo;
          cy_q[dst_q]  <= div_q ? 1'b0 : (mdu_hi != '0);
          ov_q[dst_q]  <= mdu_div0;
        end
      end
    end
  end

endmodule

// File: tb/tb_acc_bank_alu.sv
module tb_acc_bank_alu;
  import acc_bank_alu_pkg::*;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  data_src_t  data_src;
  logic [7:0] immediate, reg_out, mem_out;
  logic [1:0] acc_sel;
  alu_op_t    op;
  logic       start, ce_cy;

  logic [7:0] alu_in, acc_v, acc_hi;
  logic       flag_cy, flag_o, flag_z, flag_s, busy, done;

  logic [7:0] alu_in_nm, acc_v_nm, acc_hi_nm;
  logic       flag_cy_nm, flag_o_nm, flag_z_nm, flag_s_nm, busy_nm, done_nm;

  always #5 clk = ~clk;

  acc_bank_alu #(.WIDTH(W), .NUM_ACC(4), .MDU_EN(1)) dut (
    .clk(clk), .rst(rst), .data_src(data_src), .immediate(immediate),
    .reg_out(reg_out), .mem_out(mem_out), .acc_sel(acc_sel), .op(op),
    .start(start), .ce_cy(ce_cy), .alu_in(alu_in), .acc_v(acc_v),
    .acc_hi(acc_hi), .flag_cy(flag_cy), .flag_o(flag_o), .flag_z(flag_z),
    .flag_s(flag_s), .busy(busy), .done(done)
  );

  // Build without multiply/divide, driven by the same stimulus.
  acc_bank_alu #(.WIDTH(W), .NUM_ACC(4), .MDU_EN(0)) dut_nm (
    .clk(clk), .rst(rst), .data_src(data_src), .immediate(immediate),
    .reg_out(reg_out), .mem_out(mem_out), .acc_sel(acc_sel), .op(op),
    .start(start), .ce_cy(ce_cy), .alu_in(alu_in_nm), .acc_v(acc_v_nm),
    .acc_hi(acc_hi_nm), .flag_cy(flag_cy_nm), .flag_o(flag_o_nm), .flag_z(flag_z_nm),
    .flag_s(flag_s_nm), .busy(busy_nm), .done(done_nm)
  );

  typedef struct {
    logic [7:0] acc;
    logic [7:0] hi;
    logic       cy;
    logic       ov;
    logic       busy;
    int         due;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy === 1'b1) busy_cnt = busy_cnt + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_acc"},  acc_v,   mon_e.acc);
        chk({mon_e.name, "_hi"},   acc_hi,  mon_e.hi);
        chk({mon_e.name, "_cy"},   flag_cy, mon_e.cy);
        chk({mon_e.name, "_ov"},   flag_o,  mon_e.ov);
        chk({mon_e.name, "_z"},    flag_z,  mon_e.acc == 8'h00);
        chk({mon_e.name, "_s"},    flag_s,  mon_e.acc[7]);
        chk({mon_e.name, "_busy"}, busy,    mon_e.busy);
        chk({mon_e.name, "_lat"},  cyc,     mon_e.due);
      end
    end
  end

  // lat = cycles from the accepting edge to the done cycle: 0 single-cycle, W for MDU.
  task automatic issue(input alu_op_t o, input data_src_t s, input logic [7:0] v,
                       input logic [1:0] sel, input logic ce,
                       input logic [7:0] ea, input logic [7:0] eh,
                       input logic ecy, input logic eov, input int lat, input string nm);
    exp_t e;
    @(posedge clk); #1;
    op        = o;
    data_src  = s;
    acc_sel   = sel;
    ce_cy     = ce;
    immediate = (s == SRC_IMM) ? v : ~v;
    reg_out   = (s == SRC_REG) ? v : (v ^ 8'h5A);
    mem_out   = (s[0] == 1'b0) ? v : (v ^ 8'hA5);
    start     = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    e.acc  = ea;
    e.hi   = eh;
    e.cy   = ecy;
    e.ov   = eov;
    e.busy = (lat != 0);
    e.due  = cyc + lat;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  task automatic peek(input logic [1:0] sel, input logic [7:0] ea, input logic ez, input string nm);
    @(posedge clk); #1;
    acc_sel = sel;
    #1;
    chk({nm, "_acc"}, acc_v, ea);
    chk({nm, "_z"}, flag_z, ez);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; ce_cy = 1'b0; op = OP_ADD; data_src = SRC_IMM;
    immediate = 8'h00; reg_out = 8'h00; mem_out = 8'h00; acc_sel = 2'd0;
    #3;
    chk("rst_acc",  acc_v, 8'h00);
    chk("rst_hi",   acc_hi, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_z",    flag_z, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // ADD wrap with and without carry write
    issue(OP_LD,  SRC_IMM, 8'hF0, 2'd0, 1'b1, 8'hF0, 8'h00, 1'b0, 1'b0, 0, "ld_f0");
    drain("ld_f0");
    issue(OP_ADD, SRC_IMM, 8'h20, 2'd0, 1'b1, 8'h10, 8'h00, 1'b1, 1'b0, 0, "add_cy");
    drain("add_cy");
    issue(OP_LD,  SRC_IMM, 8'hF0, 2'd0, 1'b1, 8'hF0, 8'h00, 1'b0, 1'b0, 0, "ld_f0b");
    drain("ld_f0b");
    issue(OP_ADD, SRC_IMM, 8'h20, 2'd0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 0, "add_nocy");
    drain("add_nocy");

    // SUB signed overflow on acc1, loaded from memory
    issue(OP_LD,  SRC_MEM, 8'h80, 2'd1, 1'b1, 8'h80, 8'h00, 1'b0, 1'b0, 0, "ld_mem80");
    drain("ld_mem80");
    issue(OP_SUB, SRC_IMM, 8'h01, 2'd1, 1'b1, 8'h7F, 8'h00, 1'b0, 1'b1, 0, "sub_ov");
    drain("sub_ov");
    peek(2'd0, 8'h10, 1'b0, "iso_acc0");
    peek(2'd2, 8'h00, 1'b1, "iso_acc2");
    peek(2'd3, 8'h00, 1'b1, "iso_acc3");

    // MULU 0x12 * 0x34 = 0x03A8 with mid-RUN start and select change
    issue(OP_LD, SRC_IMM, 8'h12, 2'd2, 1'b1, 8'h12, 8'h00, 1'b0, 1'b0, 0, "ld_12");
    drain("ld_12");
    busy_cnt = 0;
    issue(OP_MULU, SRC_IMM, 8'h34, 2'd2, 1'b1, 8'hA8, 8'h03, 1'b1, 1'b0, W, "mulu");
    @(negedge clk);
    chk("mulu_busy_e0", busy, 1'b1);
    chk("nomdu_done",   done_nm, 1'b1);
    chk("nomdu_busy",   busy_nm, 1'b0);
    chk("nomdu_acc",    acc_v_nm, 8'h12);
    chk("nomdu_hi",     acc_hi_nm, 8'h00);
    @(posedge clk); #1;
    acc_sel   = 2'd0;
    op        = OP_ADD;
    data_src  = SRC_IMM;
    immediate = 8'h01;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 acc_sel = 2'd2;
    drain("mulu");
    chk("mulu_busy_cycles", busy_cnt, 32'd9);
    peek(2'd0, 8'h10, 1'b0, "mulu_acc0_kept");

    // DIVU 200 / 7 = 28 r 4, then divide by zero
    issue(OP_LD,   SRC_REG, 8'hC8, 2'd3, 1'b1, 8'hC8, 8'h03, 1'b0, 1'b0, 0, "ld_reg200");
    chk("alu_in_reg", alu_in, 8'hC8);
    drain("ld_reg200");
    issue(OP_DIVU, SRC_IMM, 8'h07, 2'd3, 1'b1, 8'h1C, 8'h04, 1'b0, 1'b0, W, "divu");
    drain("divu");
    issue(OP_LD,   SRC_IMM, 8'hC8, 2'd3, 1'b1, 8'hC8, 8'h04, 1'b0, 1'b0, 0, "ld_200b");
    drain("ld_200b");
    issue(OP_DIVU, SRC_IMM, 8'h00, 2'd3, 1'b1, 8'hFF, 8'hC8, 1'b0, 1'b1, W, "div0");
    drain("div0");

    // Reserved opcode: no state change
    issue(alu_op_t'(4'd12), SRC_IMM, 8'h55, 2'd3, 1'b1, 8'hFF, 8'hC8, 1'b0, 1'b1, 0, "rsv12");
    drain("rsv12");

    // Reset in the middle of a MULU on acc2 (holds 0xA8)
    issue(OP_MULU, SRC_IMM, 8'h02, 2'd2, 1'b1, 8'h50, 8'h01, 1'b1, 1'b0, W, "mulu_rst");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    sb.delete();
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_done", done, 1'b0);
    chk("rstmid_hi",   acc_hi, 8'h00);
    chk("rstmid_cy",   flag_cy, 1'b0);
    chk("rstmid_ov",   flag_o, 1'b0);
    for (int s = 0; s < 4; s++) begin
      acc_sel = 2'(s);
      #1;
      chk($sformatf("rstmid_acc%0d", s), acc_v, 8'h00);
    end
    @(posedge clk); #1 rst = 1'b1;
    issue(OP_ADD, SRC_IMM, 8'h05, 2'd0, 1'b1, 8'h05, 8'h00, 1'b0, 1'b0, 0, "add_after_rst");
    drain("add_after_rst");
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/acc_bank_alu.md
Name: acc_bank_alu

Overview:
Next-generation accumulator datapath: a bank of NUM_ACC accumulators, each with private carry/overflow flags, fed by the existing ALU input mux (memory/immediate/register).
Adds multi-cycle unsigned multiply and divide, producing a high/remainder word in a shared hi register.
All operations use a start/busy/done handshake.
Sits between the decoder/sequencer and the register file/memory, replacing the single-accumulator datapath.

Parameters:
WIDTH, 8, data width of accumulators, operands and hi register (>=4)
NUM_ACC, 4, number of accumulators (>=1; select width AW = max(1,$clog2(NUM_ACC)))
MDU_EN, 1, 0 removes multiply/divide; ops 8/9 then behave as reserved

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
data_src  in  data_src_t  operand source (?0 mem, 01 imm, 11 reg)
immediate  in  WIDTH  immediate operand
reg_out  in  WIDTH  register-file operand
mem_out  in  WIDTH  memory operand
acc_sel  in  AW  selected accumulator (issue target and output view)
op  in  4  operation (alu_op_t)
start  in  1  issue request, sampled at rising edge
ce_cy  in  1  carry write-enable for ops 0-7, sampled with start
alu_in  out  WIDTH  comb mux output (operand B)
acc_v  out  WIDTH  acc[acc_sel], comb view of registered bank
acc_hi  out  WIDTH  hi register (MUL high word / DIV remainder)
flag_cy  out  1  cy[acc_sel]
flag_o  out  1  ov[acc_sel]
flag_z  out  1  acc_v == 0 (comb)
flag_s  out  1  acc_v[WIDTH-1] (comb)
busy  out  1  multi-cycle op in flight
done  out  1  one-cycle pulse: result of last accepted op visible

Behaviour:
- Reset (rst=0, async): all acc, cy, ov, hi = 0; FSM IDLE; busy=0, done=0. Reset mid-operation aborts the op with no write.
- A = acc[acc_sel], B = alu_in; both sampled at the accepting edge. Start is accepted only in IDLE; start while busy is ignored with no side effects.
- Op encoding:
  - 0 ADD: A+B
  - 1 ADC: A+B+cy
  - 2 SUB: A-B
  - 3 SBB: A-B-cy
  - 4 AND, 5 OR, 6 XOR
  - 7 LD: B
  - 8 MULU, 9 DIVU
  - 10-15 reserved
- Single-cycle ops (0-7):
  - Result written to acc[acc_sel] at the accepting edge E0; done=1 in the following cycle; busy stays 0.
  - Add ops: cy = carry-out. Sub ops: cy = borrow. Logic ops and LD: cy = 0. cy is written only if ce_cy=1.
  - ov = signed overflow for add/sub ops, 0 otherwise; always written.
- Reserved ops: no writes; done pulses the next cycle.
- MULU/DIVU FSM: IDLE -E0-> RUN (WIDTH iterations, one per edge) -> DONE -> IDLE.
  - Destination index latched at E0; acc_sel may change during RUN.
  - The edge completing iteration WIDTH enters DONE and writes acc[dst] and hi.
  - done=1 and busy=1 during the DONE cycle; busy=0 from the next cycle.
  - busy is high for WIDTH+1 cycles; the result is visible WIDTH cycles after E0.
- MULU: shift-add, 2*WIDTH-bit product. acc[dst] = low word, hi = high word, cy[dst] = (hi != 0), ov[dst] = 0.
- DIVU: restoring divide. acc[dst] = quotient, hi = remainder, cy = 0, ov = 0.
  - B=0: quotient all-ones, remainder = A, ov[dst] = 1.
- Accumulators other than the destination never change. hi changes only on MULU/DIVU completion.
- flag_z and flag_s are always derived from the currently selected accumulator, with no extra storage.

Decomposition:
- Shared package (extend existing): data_src_t, alu_op_t (4-bit enum above), mdu_state_t {IDLE, RUN, DONE}.
- Reuse the existing alu_in_mux unchanged.
- One new sub-module, seq_mdu: iterative multiply/divide engine.
  - Inputs: start, is_div, a, b. Outputs: lo, hi, div0, last_iter.
  - Iteration counter width $clog2(WIDTH+1).
- Accumulator bank, flag arrays and handshake FSM stay in acc_bank_alu.

Test Plan:
- ADD wrap: acc0=0xF0, imm 0x20, op ADD, ce_cy=1 -> acc0=0x10, cy=1, o=0, z=0, done one cycle later. Repeat with ce_cy=0 -> cy unchanged.
- SUB overflow, bank isolation: acc1=0x80, imm 0x01, SUB on sel=1 -> acc1=0x7F, o=1, cy=0; acc0/acc2/acc3 unchanged; sel=2 shows z=1.
- MULU: acc2=0x12, imm 0x34 -> busy for 9 cycles, acc2=0xA8, acc_hi=0x03, cy=1. start pulsed mid-RUN is ignored; acc_sel changed mid-RUN does not move the write.
- DIVU: acc3=200, imm 7 -> acc3=0x1C, hi=0x04, ov=0. Divide by 0 -> acc3=0xFF, hi=200, ov=1.
- Reset mid-MULU (rst low at RUN iteration 3) -> busy=0, done=0, all acc/hi/flags 0 immediately. Op after release completes normally.
- Reserved op 12 -> no state change, done pulse, busy=0. MDU_EN=0 build: MULU behaves as reserved.
